// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: 32-bit valid/ready FIFO built on a synchronous-read BlockRAM,
// with a prefetch buffer that hides the RAM read latency (RD_LATENCY = 1 or 2).
`default_nettype none

module bram_fifo_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1,
   parameter int AFULL_TH   = 240
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                flush,
   input  logic                push_valid,
   output logic                push_ready,
   input  logic [DATA_W-1:0]   push_data,
   output logic                pop_valid,
   input  logic                pop_ready,
   output logic [DATA_W-1:0]   pop_data,
   output logic                ram_wr_en,
   output logic [ADDR_W-1:0]   ram_wr_addr,
   output logic [DATA_W-1:0]   ram_wr_data,
   output logic [ADDR_W-1:0]   ram_rd_addr,
   input  logic [DATA_W-1:0]   ram_rd_data,
   output logic [ADDR_W+1:0]   level,
   output logic                almost_full,
   output logic                empty
);

   localparam int OBUF_DEPTH = RD_LATENCY + 1;
   localparam int IDX_W      = $clog2(OBUF_DEPTH);
   localparam int LVL_W      = ADDR_W + 2;
   localparam logic [ADDR_W:0] RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_TH);

   logic [ADDR_W-1:0]     wr_ptr;
   logic [ADDR_W-1:0]     rd_ptr;
   logic [ADDR_W:0]       ram_level;
   logic [RD_LATENCY-1:0] tags;
   logic [DATA_W-1:0]     obuf [OBUF_DEPTH];
   logic [IDX_W-1:0]      obuf_head;
   logic [IDX_W-1:0]      obuf_tail;
   logic [1:0]            obuf_cnt;
   logic [1:0]            inflight_cnt;
   logic [2:0]            reserved;
   logic                  push_fire;
   logic                  pop_fire;
   logic                  issue;
   logic                  ret;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(OBUF_DEPTH - 1)) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         inflight_cnt = inflight_cnt + {1'b0, tags[i]};
   end

   assign ret        = tags[RD_LATENCY-1];
   assign push_ready = ram_level < RAM_DEPTH;
   // Gated by resetn so the RAM sees no write strobe while reset is held.
   assign push_fire  = resetn && push_valid && push_ready && !flush;
   assign pop_valid  = obuf_cnt != 2'd0;
   assign pop_data   = obuf[obuf_head];
   assign pop_fire   = pop_valid && pop_ready;

   // A slot freed by this cycle's pop may be reserved again at once; this keeps
   // one word per cycle in steady state without ever overrunning the buffer.
   assign reserved = {1'b0, inflight_cnt} + {1'b0, obuf_cnt} - {2'b00, pop_fire};
   assign issue    = !flush && (ram_level != '0) && (reserved < 3'(OBUF_DEPTH));

   assign ram_wr_en   = push_fire;
   assign ram_wr_addr = wr_ptr;
   assign ram_wr_data = push_fire ? push_data : '0;
   assign ram_rd_addr = rd_ptr;

   assign level       = LVL_W'(ram_level) + LVL_W'(inflight_cnt) + LVL_W'(obuf_cnt);
   assign almost_full = ram_level >= AFULL_LVL;
   assign empty       = level == '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_level <= '0;
         tags      <= '0;
         obuf_head <= '0;
         obuf_tail <= '0;
         obuf_cnt  <= '0;
         for (int i = 0; i < OBUF_DEPTH; i++)
            obuf[i] <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_level <= '0;
         tags      <= '0;
         obuf_head <= '0;
         obuf_tail <= '0;
         obuf_cnt  <= '0;
      end else begin
         if (push_fire)
            wr_ptr <= wr_ptr + 1'b1;
         if (issue)
            rd_ptr <= rd_ptr + 1'b1;
         ram_level <= ram_level + (ADDR_W+1)'(push_fire) - (ADDR_W+1)'(issue);

         tags[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++)
            tags[i] <= tags[i-1];

         if (ret) begin
            obuf[obuf_tail] <= ram_rd_data;
            obuf_tail       <= next_idx(obuf_tail);
         end
         if (pop_fire)
            obuf_head <= next_idx(obuf_head);
         obuf_cnt <= obuf_cnt + 2'(ret) - 2'(pop_fire);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: directed checks of bram_fifo_ctrl at RD_LATENCY 1 and 2,
// each instance paired with a behavioural model of the BlockRAM.
`default_nettype none

module tb_bram_fifo_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;

   logic        flush1, push_valid1, push_ready1, pop_valid1, pop_ready1;
   logic        ram_wr_en1, almost_full1, empty1;
   logic [31:0] push_data1, pop_data1, ram_wr_data1, ram_rd_data1;
   logic [7:0]  ram_wr_addr1, ram_rd_addr1;
   logic [9:0]  level1;

   logic        flush2, push_valid2, push_ready2, pop_valid2, pop_ready2;
   logic        ram_wr_en2, almost_full2, empty2;
   logic [31:0] push_data2, pop_data2, ram_wr_data2, ram_rd_data2, rd_q2;
   logic [7:0]  ram_wr_addr2, ram_rd_addr2;
   logic [9:0]  level2;

   logic [31:0] mem1 [256];
   logic [31:0] mem2 [256];

   bram_fifo_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(1), .AFULL_TH(240)) u_dut1 (
      .clk(clk), .resetn(resetn), .flush(flush1),
      .push_valid(push_valid1), .push_ready(push_ready1), .push_data(push_data1),
      .pop_valid(pop_valid1), .pop_ready(pop_ready1), .pop_data(pop_data1),
      .ram_wr_en(ram_wr_en1), .ram_wr_addr(ram_wr_addr1), .ram_wr_data(ram_wr_data1),
      .ram_rd_addr(ram_rd_addr1), .ram_rd_data(ram_rd_data1),
      .level(level1), .almost_full(almost_full1), .empty(empty1));

   bram_fifo_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(2), .AFULL_TH(240)) u_dut2 (
      .clk(clk), .resetn(resetn), .flush(flush2),
      .push_valid(push_valid2), .push_ready(push_ready2), .push_data(push_data2),
      .pop_valid(pop_valid2), .pop_ready(pop_ready2), .pop_data(pop_data2),
      .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2), .ram_wr_data(ram_wr_data2),
      .ram_rd_addr(ram_rd_addr2), .ram_rd_data(ram_rd_data2),
      .level(level2), .almost_full(almost_full2), .empty(empty2));

   // BlockRAM models: one registered read stage, plus the output register for latency 2.
   always @(posedge clk) begin
      if (ram_wr_en1) mem1[ram_wr_addr1] <= ram_wr_data1;
      ram_rd_data1 <= mem1[ram_rd_addr1];
      if (ram_wr_en2) mem2[ram_wr_addr2] <= ram_wr_data2;
      rd_q2        <= mem2[ram_rd_addr2];
      ram_rd_data2 <= rd_q2;
   end

   int max_obuf2 = 0;
   always @(negedge clk)
      if (int'(u_dut2.obuf_cnt) > max_obuf2) max_obuf2 = int'(u_dut2.obuf_cnt);

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int n_acc, drop_at, af_241, af_242, exp_i, np, bubbles, seq_bad, lvl_bad, first_c;
   int first_k, npop;
   logic [31:0] first_d;
   logic pf;

   initial begin
      resetn = 1'b1;
      {flush1, push_valid1, pop_ready1, flush2, push_valid2, pop_ready2} = '0;
      push_data1 = '0;
      push_data2 = '0;
      #1 resetn = 1'b0;
      tick;
      tick;
      check_eq("rst_push_ready", push_ready1, 1);
      check_eq("rst_empty", empty1, 1);
      check_eq("rst_pop_valid", pop_valid1, 0);
      check_eq("rst_wr_en", ram_wr_en1, 0);
      check_eq("rst_level", level1, 0);
      check_eq("rst_empty2", empty2, 1);
      resetn = 1'b1;
      tick;

      // Single word, latency 1
      push_valid1 = 1'b1; push_data1 = 32'hA5A50001; pop_ready1 = 1'b1;
      #1;
      check_eq("single_wr_en", ram_wr_en1, 1);
      check_eq("single_wr_addr", ram_wr_addr1, 0);
      check_eq("single_wr_data", ram_wr_data1, 32'hA5A50001);
      tick;
      push_valid1 = 1'b0;
      check_eq("single_lat_e0", pop_valid1, 0);
      tick;
      check_eq("single_lat_e1", pop_valid1, 0);
      tick;
      check_eq("single_lat_e2", pop_valid1, 1);
      check_eq("single_data", pop_data1, 32'hA5A50001);
      check_eq("single_level", level1, 1);
      tick;
      check_eq("single_level_end", level1, 0);
      check_eq("single_empty", empty1, 1);

      // Fill with no pops: capacity 256 RAM + 2 buffer slots
      pop_ready1 = 1'b0; n_acc = 0; drop_at = -1; af_241 = -1; af_242 = -1;
      for (int c = 0; c < 400; c++) begin
         push_valid1 = 1'b1; push_data1 = n_acc;
         #1;
         if (level1 == 10'd241) af_241 = int'(almost_full1);
         if (level1 == 10'd242) af_242 = int'(almost_full1);
         if (!push_ready1) begin
            drop_at = n_acc;
            break;
         end
         tick;
         n_acc++;
      end
      check_eq("fill_capacity", drop_at, 258);
      check_eq("fill_level", level1, 258);
      check_eq("fill_afull", almost_full1, 1);
      check_eq("fill_afull_239", af_241, 0);
      check_eq("fill_afull_240", af_242, 1);

      // Drain in order while the 259th word goes in
      pop_ready1 = 1'b1; exp_i = 0; seq_bad = 0;
      for (int c = 0; c < 700 && exp_i < 259; c++) begin
         push_valid1 = (n_acc < 259); push_data1 = n_acc;
         #1;
         pf = push_valid1 && push_ready1;
         if (pop_valid1) begin
            if (pop_data1 !== 32'(exp_i)) seq_bad++;
            exp_i++;
         end
         tick;
         if (pf) n_acc++;
      end
      push_valid1 = 1'b0;
      check_eq("fill_drain_count", exp_i, 259);
      check_eq("fill_drain_order", seq_bad, 0);
      tick;
      check_eq("fill_empty", empty1, 1);

      // Streaming 1000 words
      np = 0; exp_i = 0; bubbles = 0; seq_bad = 0; lvl_bad = 0; first_c = -1;
      for (int c = 0; c < 1200 && exp_i < 1000; c++) begin
         push_valid1 = (np < 1000); push_data1 = 32'h1000_0000 + np;
         #1;
         pf = push_valid1 && push_ready1;
         if (pop_valid1) begin
            if (first_c < 0) first_c = c;
            if (pop_data1 !== 32'h1000_0000 + exp_i) seq_bad++;
            exp_i++;
         end else if (exp_i > 0) bubbles++;
         if (c >= 3 && np < 1000 && level1 != 10'd3) lvl_bad++;
         tick;
         if (pf) np++;
      end
      push_valid1 = 1'b0;
      check_eq("stream_count", exp_i, 1000);
      check_eq("stream_order", seq_bad, 0);
      check_eq("stream_bubbles", bubbles, 0);
      check_eq("stream_level", lvl_bad, 0);
      check_eq("stream_first_lat", first_c, 3);

      // Latency 2 with random back-pressure
      np = 0; exp_i = 0; seq_bad = 0;
      for (int c = 0; c < 3000 && exp_i < 200; c++) begin
         push_valid2 = (np < 200); push_data2 = 32'hB000_0000 + np;
         pop_ready2  = 1'($urandom_range(0, 1));
         #1;
         pf = push_valid2 && push_ready2;
         if (pop_valid2 && pop_ready2) begin
            if (pop_data2 !== 32'hB000_0000 + exp_i) seq_bad++;
            exp_i++;
         end
         tick;
         if (pf) np++;
      end
      push_valid2 = 1'b0; pop_ready2 = 1'b0;
      check_eq("rnd_count", exp_i, 200);
      check_eq("rnd_order", seq_bad, 0);
      check_eq("rnd_obuf_bound", max_obuf2 <= 3, 1);
      check_eq("rnd_empty", empty2, 1);

      // Flush with two reads in flight and five words in RAM
      for (int i = 0; i < 8; i++) begin
         push_valid2 = 1'b1; push_data2 = 32'hC000_0000 + i;
         tick;
      end
      push_valid2 = 1'b0;
      tick;
      check_eq("pre_flush_level", level2, 8);
      for (int i = 0; i < 2; i++) begin
         push_valid2 = 1'b1; push_data2 = 32'hC000_0008 + i; pop_ready2 = 1'b1;
         #1;
         check_eq("pre_flush_pop", pop_data2, 32'hC000_0000 + i);
         tick;
      end
      push_valid2 = 1'b0; pop_ready2 = 1'b0;
      check_eq("pre_flush_level2", level2, 8);
      check_eq("pre_flush_head", pop_data2, 32'hC000_0002);
      flush2 = 1'b1; push_valid2 = 1'b1; push_data2 = 32'hDEAD_0000;
      #1;
      check_eq("flush_wr_en", ram_wr_en2, 0);
      tick;
      flush2 = 1'b0; push_valid2 = 1'b0;
      check_eq("flush_level", level2, 0);
      check_eq("flush_empty", empty2, 1);
      check_eq("flush_pop_valid", pop_valid2, 0);
      check_eq("flush_afull", almost_full2, 0);

      push_valid2 = 1'b1; push_data2 = 32'h1234_5678; pop_ready2 = 1'b1;
      tick;
      push_valid2 = 1'b0; first_k = -1; npop = 0; first_d = '0;
      for (int k = 0; k < 8; k++) begin
         if (pop_valid2) begin
            npop++;
            if (first_k < 0) begin
               first_k = k;
               first_d = pop_data2;
            end
         end
         tick;
      end
      check_eq("post_flush_lat", first_k, 3);
      check_eq("post_flush_data", first_d, 32'h1234_5678);
      check_eq("post_flush_npop", npop, 1);

      // Asynchronous reset between edges while streaming
      pop_ready1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push_valid1 = 1'b1; push_data1 = 32'hE000_0000 + i;
         tick;
      end
      check_eq("pre_areset_level", level1 != 10'd0, 1);
      #3 resetn = 1'b0;
      #1;
      check_eq("areset_push_ready", push_ready1, 1);
      check_eq("areset_empty", empty1, 1);
      check_eq("areset_wr_en", ram_wr_en1, 0);
      check_eq("areset_pop_valid", pop_valid1, 0);
      push_valid1 = 1'b0;
      tick;
      resetn = 1'b1;
      tick;
      push_valid1 = 1'b1; push_data1 = 32'hF000_0001;
      #1;
      check_eq("resume_wr_addr", ram_wr_addr1, 0);
      tick;
      push_valid1 = 1'b0;
      tick;
      tick;
      check_eq("resume_pop_valid", pop_valid1, 1);
      check_eq("resume_data", pop_data1, 32'hF000_0001);
      tick;
      check_eq("resume_empty", empty1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
